cube_timer_ctrl: RTL and testbench

Sequencing controller for the speedcube timer state machine (Idle -> Inspection -> Holdstart -> Timing -> Idle). It turns the raw start/stop pad into clean single-cycle advance pulses that drive the downstream state register. It enforces the hold-to-arm rule and tracks the 15 s inspection window with +2/DNF penalties. It also produces run/clear controls for the stopwatch counter and seconds-remaining for the 7-segment inspection display.

---
 rtl/cube_timer_ctrl.sv | 140 ++++++++++++++
 tb/tb_cube_timer_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_timer_ctrl.sv
// Speedcube timer sequencer: debounced pad events, hold-to-arm,
// inspection countdown with +2/DNF, stopwatch run/clear.
module cube_timer_ctrl #(
  parameter int TICKS_PER_S = 1000,
  parameter int DEB_TICKS   = 20,
  parameter int HOLD_TICKS  = 550,
  parameter int INSP_S      = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  input  logic       tick,
  output logic [1:0] state,
  output logic       advance,
  output logic       armed,
  output logic       run,
  output logic       clear,
  output logic [4:0] insp_left,
  output logic       plus2,
  output logic       dnf
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    INSP = 2'b01,
    HOLD = 2'b10,
    TIMING = 2'b11
  } st_t;

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int MW = $clog2(TICKS_PER_S);
  localparam int SW = $clog2(INSP_S + 3);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
  localparam logic [MW-1:0] MS_LAST  = MW'(TICKS_PER_S - 1);
  localparam logic [SW-1:0] S_PEN    = SW'(INSP_S);
  localparam logic [SW-1:0] S_DNF    = SW'(INSP_S + 2);

  st_t st_q, st_n;
  logic s1, s2, lvl, press, rel;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic [MW-1:0] ms;
  logic [SW-1:0] secs;

  // Level flips only after DEB_TICKS disagreeing tick samples in a row
  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      dcnt  <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= button;
      s2    <= s1;
      press <= 1'b0;
      rel   <= 1'b0;
      if (tick) begin
        if (s2 != lvl) begin
          if (dcnt == DEB_LAST) begin
            lvl   <= s2;
            dcnt  <= '0;
            press <= s2;
            rel   <= ~s2;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end else begin
          dcnt <= '0;
        end
      end
    end
  end

  assign armed = (st_q == HOLD) && (hcnt == HOLD_MAX);

  always_comb begin
    st_n = st_q;
    unique case (st_q)
      IDLE:    if (press) st_n = INSP;
      INSP:    if (press) st_n = HOLD;
      HOLD:    if (rel && armed) st_n = TIMING;
      TIMING:  if (press) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= IDLE;
      advance <= 1'b0;
      clear   <= 1'b0;
    end else begin
      st_q    <= st_n;
      advance <= (st_n != st_q);
      clear   <= (st_q == IDLE) && press;
    end
  end

  // Hold counter lives only in Holdstart; an unarmed release restarts it
  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt <= '0;
    end else if (st_q != HOLD) begin
      hcnt <= '0;
    end else if (rel && !armed) begin
      hcnt <= '0;
    end else if (lvl && tick && !armed) begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ms   <= '0;
      secs <= '0;
    end else if (st_q == IDLE && press) begin
      ms   <= '0;
      secs <= '0;
    end else if ((st_q == INSP || st_q == HOLD) && tick && secs != S_DNF) begin
      if (ms == MS_LAST) begin
        ms   <= '0;
        secs <= secs + 1'b1;
      end else begin
        ms <= ms + 1'b1;
      end
    end
  end

  assign state     = st_q;
  assign run       = (st_q == TIMING);
  assign plus2     = (secs >= S_PEN);
  assign dnf       = (secs == S_DNF);
  assign insp_left = (secs >= S_PEN) ? 5'd0 : 5'(S_PEN - secs);

endmodule

// File: tb/tb_cube_timer_ctrl.sv
// Bench for cube_timer_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_cube_timer_ctrl;

  localparam int TPS  = 1000;
  localparam int DEB  = 20;
  localparam int HOLDT = 550;
  localparam int INSP = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic button = 1'b0;
  logic tick = 1'b0;
  logic [1:0] state;
  logic advance, armed, run, clear, plus2, dnf;
  logic [4:0] insp_left;

  cube_timer_ctrl #(
    .TICKS_PER_S(TPS),
    .DEB_TICKS(DEB),
    .HOLD_TICKS(HOLDT),
    .INSP_S(INSP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .button(button),
    .tick(tick),
    .state(state),
    .advance(advance),
    .armed(armed),
    .run(run),
    .clear(clear),
    .insp_left(insp_left),
    .plus2(plus2),
    .dnf(dnf)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int adv_cnt = 0;
  int clr_cnt = 0;
  bit go = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: button delayed two cycles, debounced level, events,
  // elapsed inspection ticks as a plain integer.
  int m_s1, m_s2, m_lvl, m_run, m_press, m_rel;
  int m_state, m_adv, m_clear, m_el, m_hold;

  initial begin : model
    int ps, ns, arm;
    forever begin
      @(posedge clock);
      go = 1'b1;
      if (reset) begin
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
        m_press = 0; m_rel = 0; m_state = 0; m_adv = 0;
        m_clear = 0; m_el = 0; m_hold = 0;
      end else begin
        ps = m_state;
        ns = ps;
        arm = (ps == 2 && m_hold == HOLDT) ? 1 : 0;
        if (ps == 0 && m_press == 1) ns = 1;
        else if (ps == 1 && m_press == 1) ns = 2;
        else if (ps == 2 && m_rel == 1 && arm == 1) ns = 3;
        else if (ps == 3 && m_press == 1) ns = 0;
        m_clear = (ps == 0 && m_press == 1) ? 1 : 0;
        if (ps != 2) m_hold = 0;
        else if (m_rel == 1 && arm == 0) m_hold = 0;
        else if (m_lvl == 1 && tick && m_hold < HOLDT) m_hold++;
        if (ps == 0 && m_press == 1) m_el = 0;
        else if ((ps == 1 || ps == 2) && tick && m_el < (INSP + 2) * TPS)
          m_el++;
        m_adv = (ns != ps) ? 1 : 0;
        m_state = ns;
        m_press = 0;
        m_rel = 0;
        if (tick) begin
          if (m_s2 != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin
              m_lvl = m_s2;
              m_run = 0;
              m_press = m_lvl;
              m_rel = 1 - m_lvl;
            end
          end else begin
            m_run = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = int'(button);
      end
    end
  end

  // Downstream state machine clocked by advance
  logic [1:0] ds = 2'd0;
  bit seen_adv = 1'b0;
  always @(posedge clock) begin
    if (reset) begin
      ds <= 2'd0;
      seen_adv <= 1'b0;
    end else if (advance) begin
      ds <= ds + 2'd1;
      seen_adv <= 1'b1;
    end
  end

  initial begin : compare
    int secs, left;
    forever begin
      @(negedge clock);
      if (go) begin
        secs = m_el / TPS;
        left = (secs >= INSP) ? 0 : INSP - secs;
        chk("state", int'(state), m_state);
        chk("advance", int'(advance), m_adv);
        chk("clear", int'(clear), m_clear);
        chk("run", int'(run), (m_state == 3) ? 1 : 0);
        chk("armed", int'(armed), (m_state == 2 && m_hold == HOLDT) ? 1 : 0);
        chk("insp_left", int'(insp_left), left);
        chk("plus2", int'(plus2), (m_el >= INSP * TPS) ? 1 : 0);
        chk("dnf", int'(dnf), (m_el >= (INSP + 2) * TPS) ? 1 : 0);
        if (seen_adv && !advance && !reset)
          chk("lockstep", int'(ds), int'(state));
        if (advance) adv_cnt++;
        if (clear) clr_cnt++;
      end
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
    end
  endtask

  task automatic set_btn(input logic v);
    button = v;
    repeat (3) @(negedge clock);
    ticks(DEB);
    repeat (2) @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  int a0, c0, len;

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_left", int'(insp_left), 15);
    chk("rst_adv", int'(advance), 0);

    // bounce rejection then a clean hold
    a0 = adv_cnt; c0 = clr_cnt;
    for (int s = 0; s < 20; s++) begin
      button = (s % 2 == 0);
      ticks(5);
    end
    button = 1'b1;
    ticks(25);
    repeat (2) @(negedge clock);
    #1;
    chk("bounce_state", int'(state), 1);
    chk("bounce_adv", adv_cnt - a0, 1);
    chk("bounce_clr", clr_cnt - c0, 1);

    // countdown and penalties
    button = 1'b0;
    do_reset();
    repeat (30) @(negedge clock);
    set_btn(1'b1);
    chk("cd_state", int'(state), 1);
    ticks(1);
    #1 chk("cd_left_1", int'(insp_left), 15);
    ticks(999);
    #1 chk("cd_left_1000", int'(insp_left), 14);
    ticks(13999);
    #1 chk("cd_left_14999", int'(insp_left), 1);
    chk("cd_plus2_14999", int'(plus2), 0);
    ticks(1);
    #1 chk("cd_left_15000", int'(insp_left), 0);
    chk("cd_plus2_15000", int'(plus2), 1);
    ticks(1999);
    #1 chk("cd_dnf_16999", int'(dnf), 0);
    ticks(1);
    #1 chk("cd_dnf_17000", int'(dnf), 1);

    // early release then full hold
    set_btn(1'b0);
    chk("insp_rel_state", int'(state), 1);
    set_btn(1'b1);
    chk("hold_state", int'(state), 2);
    ticks(300);
    a0 = adv_cnt;
    set_btn(1'b0);
    chk("early_state", int'(state), 2);
    chk("early_armed", int'(armed), 0);
    set_btn(1'b1);
    ticks(549);
    #1 chk("armed_549", int'(armed), 0);
    ticks(1);
    #1 chk("armed_550", int'(armed), 1);
    chk("early_adv", adv_cnt - a0, 0);
    set_btn(1'b0);
    chk("timing_state", int'(state), 3);
    chk("timing_run", int'(run), 1);
    chk("timing_armed", int'(armed), 0);
    chk("timing_adv", adv_cnt - a0, 1);
    chk("timing_plus2", int'(plus2), 1);
    set_btn(1'b1);
    chk("idle_state", int'(state), 0);
    chk("idle_run", int'(run), 0);
    chk("idle_dnf", int'(dnf), 1);
    set_btn(1'b0);
    set_btn(1'b1);
    chk("reins_state", int'(state), 1);
    chk("reins_plus2", int'(plus2), 0);
    chk("reins_dnf", int'(dnf), 0);
    set_btn(1'b0);
    set_btn(1'b1);
    ticks(560);
    set_btn(1'b0);
    chk("t2_state", int'(state), 3);

    // reset mid-Timing
    do_reset();
    chk("rmt_state", int'(state), 0);
    chk("rmt_run", int'(run), 0);
    chk("rmt_adv", int'(advance), 0);
    chk("rmt_left", int'(insp_left), 15);
    chk("rmt_plus2", int'(plus2), 0);
    chk("rmt_dnf", int'(dnf), 0);

    // randomized traffic
    for (int seg = 0; seg < 60; seg++) begin
      button = ~button;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1500, 2500);
      else len = $urandom_range(1, 200);
      for (int c = 0; c < len; c++) begin
        @(negedge clock);
        tick = (!tick) && ($urandom_range(0, 2) == 0);
        reset = ($urandom_range(0, 6000) == 0);
      end
      if (total > 0 && seg == 59) begin
        @(negedge clock);
        tick = 1'b0;
        reset = 1'b0;
      end
    end
    repeat (5) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
